// File: rtl/isa_defs_pkg.sv
// Shared definitions for the instruction sequencer: FSM state encoding,
// default wait-state timeout and a small state classification helper.
package isa_defs_pkg;

    // Default number of consecutive cycles allowed in a wait state.
    localparam int WAIT_LIMIT_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FETCH      = 3'd1,
        FETCH_WAIT = 3'd2,
        EXEC       = 3'd3,
        MEM        = 3'd4,
        WB         = 3'd5,
        ERR        = 3'd6
    } seq_state_e;

    // States in which the sequencer waits on an external handshake and
    // is therefore guarded by the wait timer.
    function automatic logic is_wait_state(input seq_state_e s);
        return (s == FETCH) || (s == FETCH_WAIT) || (s == MEM);
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Wait-state timer: counts cycles spent in a handshake wait state and flags
// the cycle that is the LIMIT-th consecutive one, so a handshake arriving in
// that same cycle can still be honoured by the caller.
module wait_timer
    import isa_defs_pkg::*;
#(
    parameter int LIMIT = WAIT_LIMIT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_limit
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] r_count;

    // r_count = cycles already completed in the current wait state; it
    // saturates at LIMIT-1 so it never wraps while the caller errors out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_limit) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_limit = (r_count == CW'(LIMIT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetches an instruction over a
// req/gnt/rvalid port, holds it for the decoder, performs an optional data
// memory access, then strobes PC advance and register writeback. Every
// handshake wait is bounded by a wait timer; a timeout parks the FSM in ERR
// until reset.
module instr_sequencer
    import isa_defs_pkg::*;
#(
    parameter int WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt_req,
    output logic        imem_req,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    input  logic        dec_mem_read,
    input  logic        dec_mem_write,
    input  logic        dec_reg_write_en,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        pc_en,
    output logic        rf_we,
    output logic        busy,
    output logic        err,
    output logic [31:0] instr_count
);

    seq_state_e  r_state;
    seq_state_e  w_state_next;
    logic [31:0] r_instr;
    logic [31:0] r_instr_count;
    logic        w_capture;
    logic        w_timer_clear;
    logic        w_timer_en;
    logic        w_timer_limit;

    // The timer restarts whenever a wait state is freshly entered and runs
    // for as long as the FSM remains in one.
    assign w_timer_clear = (w_state_next != r_state) && is_wait_state(w_state_next);
    assign w_timer_en    = is_wait_state(r_state);

    wait_timer #(
        .LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_timer_clear),
        .i_enable (w_timer_en),
        .o_limit  (w_timer_limit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and Moore/Mealy outputs; a handshake is tested before the
    // timeout so one arriving in the limit cycle still wins.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        pc_en        = 1'b0;
        rf_we        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = FETCH;
                end
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_gnt) begin
                    w_state_next = FETCH_WAIT;
                end else if (w_timer_limit) begin
                    w_state_next = ERR;
                end
            end
            FETCH_WAIT: begin
                if (imem_rvalid) begin
                    w_capture    = 1'b1;
                    w_state_next = EXEC;
                end else if (w_timer_limit) begin
                    w_state_next = ERR;
                end
            end
            EXEC: begin
                if (dec_mem_read || dec_mem_write) begin
                    w_state_next = MEM;
                end else begin
                    w_state_next = WB;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_mem_write;
                if (dmem_ready) begin
                    w_state_next = WB;
                end else if (w_timer_limit) begin
                    w_state_next = ERR;
                end
            end
            WB: begin
                pc_en = 1'b1;
                rf_we = dec_reg_write_en;
                if (halt_req) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = FETCH;
                end
            end
            ERR: begin
                w_state_next = ERR;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Instruction latch: only the fetch-data capture may change it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= '0;
        end else if (w_capture) begin
            r_instr <= imem_rdata;
        end
    end

    // Retired-instruction counter, advanced once per writeback; wraps freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_count <= '0;
        end else if (r_state == WB) begin
            r_instr_count <= r_instr_count + 32'd1;
        end
    end

    assign instr       = r_instr;
    assign instr_count = r_instr_count;
    assign busy        = (r_state != IDLE);
    assign err         = (r_state == ERR);

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 16, meaning max consecutive cycles spent in any wait state before error.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  begin execution; honoured only in IDLE.
REQ-005 SHALL have port halt_req  input  1  level; stop after current instruction.
REQ-006 SHALL have port imem_req  output  1  instruction fetch request.
REQ-007 SHALL have port imem_gnt  input  1  fetch request accepted.
REQ-008 SHALL have port imem_rvalid  input  1  fetch data valid; never asserted before the cycle after imem_gnt.
REQ-009 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-010 SHALL have port instr  output  32  latched instruction, driven to decoder.
REQ-011 SHALL have ports dec_mem_read, dec_mem_write, dec_reg_write_en  input  1 each  decoder controls for instr.
REQ-012 SHALL have ports dmem_req, dmem_we  output  1 each  data memory request / write qualifier.
REQ-013 SHALL have port dmem_ready  input  1  data access complete.
REQ-014 SHALL have ports pc_en, rf_we  output  1 each  one-cycle PC-advance / register-writeback strobes.
REQ-015 SHALL have ports busy, err  output  1 each  not-IDLE / sticky timeout flag.
REQ-016 SHALL have port instr_count  output  32  retired-instruction count.

Function
REQ-017 SHALL implement states IDLE, FETCH, FETCH_WAIT, EXEC, MEM, WB, ERR.
REQ-018 IDLE: start=1 -> FETCH next cycle; otherwise stay.
REQ-019 FETCH: imem_req=1 held until imem_gnt=1, then -> FETCH_WAIT.
REQ-020 FETCH_WAIT: imem_req=0; on imem_rvalid=1 latch imem_rdata into instr, -> EXEC.
REQ-021 EXEC: one cycle for decode; dec_mem_read|dec_mem_write -> MEM, else -> WB.
REQ-022 MEM: dmem_req=1, dmem_we=dec_mem_write, held until dmem_ready=1, then -> WB.
REQ-023 WB: pc_en=1, rf_we=dec_reg_write_en, instr_count+1 (wraps 0xFFFFFFFF -> 0); halt_req=1 -> IDLE, else -> FETCH.
REQ-024 Zero-wait memories: non-memory instruction SHALL retire every 4 cycles, LOAD/STORE every 5.
REQ-025 Wait counter SHALL clear on entry to FETCH, FETCH_WAIT, MEM; count each cycle there; reaching WAIT_LIMIT without handshake -> ERR.
REQ-026 Handshake arriving in the same cycle the counter reaches WAIT_LIMIT SHALL win (normal transition, no error).
REQ-027 ERR: all request/strobe outputs 0, err=1, busy=1; exit only via reset.
REQ-028 start outside IDLE and halt_req outside WB SHALL be ignored (halt_req sampled only in WB).
REQ-029 instr SHALL hold its value except on the FETCH_WAIT capture.
REQ-030 busy SHALL be 1 in every state except IDLE.

Reset
REQ-031 rst_n=0 SHALL force IDLE, instr=0, instr_count=0, err=0, wait counter=0, all outputs 0, asynchronously, including mid-fetch or mid-memory access.
REQ-032 First FETCH after reset release SHALL require a fresh start pulse.

Structure
REQ-033 seq_state_e enum and WAIT_LIMIT default constant SHALL live in isa_defs_pkg.
REQ-034 Wait counter SHALL be one sub-module, wait_timer (clear, enable, limit-reached output).

Verification
REQ-035 start pulse, zero-wait memories, ADDI then NOP -> pc_en pulses at cycles 4 and 8 after start, rf_we=1 only at first, instr_count=2.
REQ-036 LOAD with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, WB follows, rf_we=1.
REQ-037 imem_gnt never asserted, WAIT_LIMIT=16 -> err=1 after 16 FETCH cycles, imem_req=0 thereafter until reset.
REQ-038 halt_req=1 during EXEC of STORE -> instruction completes (dmem_we=1, rf_we=0), returns IDLE, busy=0.
REQ-039 rst_n low during MEM -> dmem_req=0 immediately, state IDLE, instr_count=0 after release.
REQ-040 preload instr_count 0xFFFFFFFF via force, retire one NOP -> instr_count=0.
